// File: rtl/draw_arbiter_pkg.sv
// Shared VGA geometry constants, arbiter state encoding and packed-bus slice helpers.
package vga_pkg;

    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int C_W       = 3;
    localparam int X_MAX     = 159;
    localparam int Y_MAX     = 119;
    localparam int MAX_NREQ  = 8;
    localparam int IDX_MAX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Buses are passed zero-extended to the widest legal requester count.
    function automatic logic [X_W-1:0] slice_x(input logic [X_W*MAX_NREQ-1:0] bus,
                                               input logic [IDX_MAX_W-1:0]     idx);
        return bus[int'(idx)*X_W +: X_W];
    endfunction

    function automatic logic [Y_W-1:0] slice_y(input logic [Y_W*MAX_NREQ-1:0] bus,
                                               input logic [IDX_MAX_W-1:0]     idx);
        return bus[int'(idx)*Y_W +: Y_W];
    endfunction

    function automatic logic [C_W-1:0] slice_c(input logic [C_W*MAX_NREQ-1:0] bus,
                                               input logic [IDX_MAX_W-1:0]     idx);
        return bus[int'(idx)*C_W +: C_W];
    endfunction

endpackage

// File: rtl/draw_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module rr_picker #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] winner_o
);

    // Scan NREQ candidates starting one past the previous winner.
    always_comb begin
        int cand;
        cand     = 0;
        valid_o  = 1'b0;
        winner_o = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_i) + k) % NREQ;
            if (!valid_o && req_i[cand]) begin
                valid_o  = 1'b1;
                winner_o = cand[IDX_W-1:0];
            end else begin
                valid_o  = valid_o;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one VGA plot port between NREQ start/done drawing engines.
module draw_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       req_done,
    output logic                  busy,
    output logic [NREQ-1:0]       eng_start,
    input  logic [NREQ-1:0]       eng_done,
    input  logic [X_W*NREQ-1:0]   eng_x,
    input  logic [Y_W*NREQ-1:0]   eng_y,
    input  logic [C_W*NREQ-1:0]   eng_colour,
    input  logic [NREQ-1:0]       eng_plot,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [C_W-1:0]        vga_colour,
    output logic                  vga_plot
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int XB_W  = X_W * MAX_NREQ;
    localparam int YB_W  = Y_W * MAX_NREQ;
    localparam int CB_W  = C_W * MAX_NREQ;

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_RUN     = 2'(RUN);
    localparam logic [1:0] ST_RELEASE = 2'(RELEASE);

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [NREQ-1:0]      sel_onehot_s;
    logic [IDX_MAX_W-1:0] sel_ext_s;
    logic [XB_W-1:0]      eng_x_ext_s;
    logic [YB_W-1:0]      eng_y_ext_s;
    logic [CB_W-1:0]      eng_c_ext_s;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i    (req),
        .last_i   (last_q),
        .valid_o  (pick_valid_s),
        .winner_o (pick_idx_s)
    );

    // State, selected engine and round-robin pointer; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= IDX_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic; a running job ends only on its own engine's done.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_RUN;
                    sel_d   = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (eng_done[sel_q]) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RELEASE: begin
                last_d  = sel_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;

    // Handshake outputs decoded straight from state so reset clears them without a clock.
    always_comb begin
        grant     = '0;
        eng_start = '0;
        req_done  = '0;
        busy      = 1'b0;
        vga_plot  = 1'b0;
        case (state_q)
            ST_RUN: begin
                grant     = sel_onehot_s;
                eng_start = sel_onehot_s;
                busy      = 1'b1;
                vga_plot  = eng_plot[sel_q] & ~eng_done[sel_q];
            end
            ST_RELEASE: begin
                grant    = sel_onehot_s;
                req_done = sel_onehot_s;
                busy     = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign sel_ext_s   = IDX_MAX_W'(sel_q);
    assign eng_x_ext_s = XB_W'(eng_x);
    assign eng_y_ext_s = YB_W'(eng_y);
    assign eng_c_ext_s = CB_W'(eng_colour);

    assign vga_x      = slice_x(eng_x_ext_s, sel_ext_s);
    assign vga_y      = slice_y(eng_y_ext_s, sel_ext_s);
    assign vga_colour = slice_c(eng_c_ext_s, sel_ext_s);

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter with simple start/done engine models on every requester.
module tb_draw_arbiter;

    localparam int NREQ = 3;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req   = '0;
    logic [NREQ-1:0]     grant, req_done, eng_start, eng_done, eng_plot;
    logic                busy, vga_plot;
    logic [8*NREQ-1:0]   eng_x;
    logic [7*NREQ-1:0]   eng_y;
    logic [3*NREQ-1:0]   eng_colour;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [2:0]          vga_colour;

    int checks = 0;
    int errors = 0;

    int         len_cfg  [NREQ];
    bit         fill_cfg [NREQ];
    logic [2:0] col_cfg  [NREQ];

    always #5 clk = ~clk;

    draw_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .req_done   (req_done),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_colour (eng_colour),
        .eng_plot   (eng_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    // Engine model: len_cfg plot cycles, then done held until start drops.
    for (genvar g = 0; g < NREQ; g++) begin : g_eng
        int   cnt = 0;
        logic dn  = 1'b0;
        always @(posedge clk) begin
            if (!eng_start[g]) begin
                cnt <= 0;
                dn  <= 1'b0;
            end else if (!dn) begin
                if (cnt >= len_cfg[g] - 1) dn <= 1'b1;
                cnt <= cnt + 1;
            end
        end
        assign eng_done[g]          = dn;
        assign eng_plot[g]          = eng_start[g] && !dn && (cnt < len_cfg[g]);
        assign eng_x[8*g +: 8]      = fill_cfg[g] ? 8'(cnt / 120) : 8'(cnt);
        assign eng_y[7*g +: 7]      = fill_cfg[g] ? 7'(cnt % 120) : 7'd0;
        assign eng_colour[3*g +: 3] = col_cfg[g];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < NREQ; i++) begin
            len_cfg[i]  = 3;
            fill_cfg[i] = 1'b0;
            col_cfg[i]  = 3'(i + 1);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", grant); end
        checks++; if (eng_start !== 3'b000) begin errors++; $display("FAIL reset_start got %b want 000", eng_start); end
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL reset_done got %b want 000", req_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b want 0", vga_plot); end
    endtask

    task automatic test_single_job();
        int plots = 0;
        int dones = 0;
        int cyc   = 0;
        bit fin   = 1'b0;
        apply_reset();
        len_cfg[1] = 4;
        col_cfg[1] = 3'b101;
        req = 3'b010;
        tick();
        checks++; if (eng_start !== 3'b010) begin errors++; $display("FAIL single_start got %b want 010", eng_start); end
        while (!fin && cyc < 40) begin
            if (vga_plot) begin
                checks++;
                if (vga_x !== 8'(plots) || vga_y !== 7'd0 || vga_colour !== 3'b101) begin
                    errors++;
                    $display("FAIL single_pixel got (%0d,%0d,%b) want (%0d,0,101)", vga_x, vga_y, vga_colour, plots);
                end
                plots++;
            end
            if (req_done != 3'b000) begin
                dones++;
                checks++; if (req_done !== 3'b010) begin errors++; $display("FAIL single_done_idx got %b want 010", req_done); end
                req = 3'b000;
            end
            if (dones > 0 && !busy) fin = 1'b1;
            if (!fin) begin tick(); cyc++; end
        end
        checks++; if (!fin) begin errors++; $display("FAIL single_timeout got busy=%b want 0", busy); end
        checks++; if (plots != 4) begin errors++; $display("FAIL single_plots got %0d want 4", plots); end
        checks++; if (dones != 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", dones); end
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_grant_end got %b want 000", grant); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] seq     [4] = '{3'b000, 3'b000, 3'b000, 3'b000};
        int         gaps    [4] = '{0, 0, 0, 0};
        logic [2:0] prev  = 3'b000;
        int         nrise = 0;
        int         gap   = 0;
        int         cyc   = 0;
        bit         fin   = 1'b0;
        apply_reset();
        req = 3'b111;
        while (!fin && cyc < 200) begin
            tick();
            cyc++;
            if (eng_start != 3'b000 && prev == 3'b000 && nrise < 4) begin
                seq[nrise]  = eng_start;
                gaps[nrise] = gap;
                nrise++;
                if (nrise == 4) req = 3'b000;
            end
            if (eng_start == 3'b000) gap++; else gap = 0;
            prev = eng_start;
            if (nrise == 4 && !busy) fin = 1'b1;
        end
        checks++; if (!fin) begin errors++; $display("FAIL rr_timeout got %0d grants want 4", nrise); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seq[k] !== exp_seq[k]) begin errors++; $display("FAIL rr_seq[%0d] got %b want %b", k, seq[k], exp_seq[k]); end
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (gaps[k] != 2) begin errors++; $display("FAIL rr_gap[%0d] got %0d want 2", k, gaps[k]); end
        end
    endtask

    task automatic test_priority();
        logic [2:0] seq [2] = '{3'b000, 3'b000};
        logic [2:0] prev  = 3'b000;
        int         nrise = 0;
        int         cyc   = 0;
        bit         fin   = 1'b0;
        apply_reset();
        len_cfg[0] = 2;
        len_cfg[2] = 2;
        req = 3'b101;
        while (!fin && cyc < 100) begin
            tick();
            cyc++;
            if (eng_start != 3'b000 && prev == 3'b000) begin
                if (nrise < 2) seq[nrise] = eng_start;
                nrise++;
            end
            prev = eng_start;
            if (req_done != 3'b000) req = req & ~req_done;
            if (req == 3'b000 && !busy) fin = 1'b1;
        end
        checks++; if (!fin) begin errors++; $display("FAIL prio_timeout got req=%b want 000", req); end
        checks++; if (nrise != 2) begin errors++; $display("FAIL prio_count got %0d want 2", nrise); end
        checks++; if (seq[0] !== 3'b001) begin errors++; $display("FAIL prio_first got %b want 001", seq[0]); end
        checks++; if (seq[1] !== 3'b100) begin errors++; $display("FAIL prio_second got %b want 100", seq[1]); end
    endtask

    task automatic test_req_drop();
        int start_cnt = 0;
        int dones     = 0;
        int cyc       = 0;
        bit fin       = 1'b0;
        apply_reset();
        len_cfg[2] = 5;
        req = 3'b100;
        while (!fin && cyc < 40) begin
            tick();
            cyc++;
            if (eng_start == 3'b100) start_cnt++;
            if (start_cnt == 2) req = 3'b000;
            if (req_done != 3'b000) begin
                dones++;
                checks++; if (req_done !== 3'b100) begin errors++; $display("FAIL drop_done_idx got %b want 100", req_done); end
            end
            if (dones > 0 && !busy) fin = 1'b1;
        end
        checks++; if (!fin) begin errors++; $display("FAIL drop_timeout got busy=%b want 0", busy); end
        checks++; if (start_cnt != 6) begin errors++; $display("FAIL drop_start_cycles got %0d want 6", start_cnt); end
        checks++; if (dones != 1) begin errors++; $display("FAIL drop_done_pulses got %0d want 1", dones); end
    endtask

    task automatic test_reset_mid_run();
        int cyc = 0;
        bit fin = 1'b0;
        apply_reset();
        len_cfg[1] = 10;
        req = 3'b010;
        tick();
        tick();
        tick();
        checks++; if (vga_plot !== 1'b1) begin errors++; $display("FAIL midrst_pre_plot got %b want 1", vga_plot); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (eng_start !== 3'b000) begin errors++; $display("FAIL midrst_start got %b want 000", eng_start); end
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL midrst_grant got %b want 000", grant); end
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL midrst_plot got %b want 0", vga_plot); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (eng_start !== 3'b010) begin errors++; $display("FAIL midrst_restart got %b want 010", eng_start); end
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd0) begin
            errors++;
            $display("FAIL midrst_fresh got plot=%b x=%0d want plot=1 x=0", vga_plot, vga_x);
        end
        while (!fin && cyc < 60) begin
            tick();
            cyc++;
            if (req_done != 3'b000) req = 3'b000;
            if (req == 3'b000 && !busy) fin = 1'b1;
        end
        checks++; if (!fin) begin errors++; $display("FAIL midrst_timeout got busy=%b want 0", busy); end
    endtask

    task automatic test_fullscreen();
        bit covered [160][120];
        int plots   = 0;
        int overlap = 0;
        int badc    = 0;
        int oor     = 0;
        int dup     = 0;
        int cov     = 0;
        int e1plots = 0;
        int cyc     = 0;
        bit fin0    = 1'b0;
        bit fin1    = 1'b0;
        apply_reset();
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                covered[x][y] = 1'b0;
        fill_cfg[0] = 1'b1;
        len_cfg[0]  = 19200;
        col_cfg[0]  = 3'b011;
        len_cfg[1]  = 4;
        req = 3'b011;
        while (!fin0 && cyc < 19400) begin
            tick();
            cyc++;
            if (eng_start[1]) overlap++;
            if (vga_plot) begin
                plots++;
                if (grant !== 3'b001) overlap++;
                if (vga_colour !== 3'b011) badc++;
                if (vga_x > 8'd159 || vga_y > 7'd119) oor++;
                else if (covered[vga_x][vga_y]) dup++;
                else covered[vga_x][vga_y] = 1'b1;
            end
            if (req_done[0]) begin
                req  = 3'b010;
                fin0 = 1'b1;
            end
        end
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                if (covered[x][y]) cov++;
        cyc = 0;
        while (!fin1 && cyc < 60) begin
            tick();
            cyc++;
            if (vga_plot && grant === 3'b010) e1plots++;
            if (req_done[1]) req = 3'b000;
            if (req == 3'b000 && !busy) fin1 = 1'b1;
        end
        checks++; if (!fin0) begin errors++; $display("FAIL fill_timeout got plots=%0d want 19200", plots); end
        checks++; if (plots != 19200) begin errors++; $display("FAIL fill_plots got %0d want 19200", plots); end
        checks++; if (cov != 19200) begin errors++; $display("FAIL fill_coverage got %0d want 19200", cov); end
        checks++; if (dup != 0 || oor != 0) begin errors++; $display("FAIL fill_dup_oor got %0d/%0d want 0/0", dup, oor); end
        checks++; if (badc != 0) begin errors++; $display("FAIL fill_colour got %0d bad want 0", badc); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL fill_overlap got %0d want 0", overlap); end
        checks++; if (!fin1 || e1plots != 4) begin errors++; $display("FAIL fill_eng1 got %0d plots want 4", e1plots); end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_priority();
        test_req_drop();
        test_reset_mid_run();
        test_fullscreen();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
